// File: rtl/gcd_unit_arbiter.sv
// gcd_unit_arbiter: round-robin sharing of one multi-cycle two-operand unit among NREQ requesters
module gcd_unit_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [IDW-1:0]  resp_id,
  output logic [W-1:0]    resp_res,
  output logic            resp_err,
  input  logic            unit_input_ready,
  output logic            unit_input_valid,
  output logic [W-1:0]    unit_x,
  output logic [W-1:0]    unit_y,
  input  logic            unit_output_valid,
  input  logic [W-1:0]    unit_res
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2, RESP = 2'd3;
  logic [1:0] state;
  logic [IDW-1:0] ptr, gid, gnt, cand;
  logic any, ov_q, done, tmo;
  logic [CW-1:0] cnt;
  logic [W-1:0] x_q, y_q;
  // scan downwards so the lowest offset from the pointer wins
  always_comb begin
    gnt = ptr;
    any = 1'b0;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (req_valid[cand]) begin
        gnt = cand;
        any = 1'b1;
      end
    end
  end
  assign done = unit_output_valid && !ov_q;
  assign tmo = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
  // gated by reset so no accept pulse is shown while the block is held in reset
  assign req_ready = (reset_n && state == IDLE && any && unit_input_ready) ? NREQ'(1) << gnt : '0;
  assign unit_input_valid = state == ISSUE;
  assign resp_valid = state == RESP;
  assign resp_id = gid;
  assign unit_x = x_q;
  assign unit_y = y_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr <= '0;
      gid <= '0;
      ov_q <= 1'b0;
      cnt <= '0;
      x_q <= '0;
      y_q <= '0;
      resp_res <= '0;
      resp_err <= 1'b0;
    end else begin
      ov_q <= unit_output_valid;
      if (state == IDLE && any && unit_input_ready) begin
        state <= ISSUE;
        gid <= gnt;
        x_q <= req_x[gnt*W +: W];
        y_q <= req_y[gnt*W +: W];
      end
      if (state == ISSUE && unit_input_ready) begin
        state <= BUSY;
        cnt <= '0;
      end
      if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        if (done || tmo) begin
          state <= RESP;
          resp_res <= done ? unit_res : '0;
          resp_err <= !done;
        end
      end
      if (state == RESP && resp_ready) begin
        state <= IDLE;
        ptr <= gid == IDW'(NREQ - 1) ? '0 : gid + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gcd_unit_arbiter.sv
// tb_gcd_unit_arbiter: scoreboard bench with behavioural GCD unit models
module tb_gcd_unit_arbiter;
  logic clk = 0, reset_n = 1;
  always #5 clk = ~clk;
  logic [3:0] req_valid = '0, req_ready, pend = '0;
  logic [127:0] req_x = '0, req_y = '0;
  logic resp_valid, resp_ready = 1, resp_err;
  logic [1:0] resp_id;
  logic [31:0] resp_res, unit_x, unit_y;
  logic u_iv, u_ir, u_ov = 0, ir_en = 1, busy = 0;
  logic [31:0] u_res = 0, m_r = 0;
  int cnt = 0;
  logic [3:0] t_req_valid = '0, t_req_ready, t_pend = '0;
  logic [127:0] t_req_x = '0, t_req_y = '0;
  logic t_resp_valid, t_resp_ready = 1, t_resp_err;
  logic [1:0] t_resp_id;
  logic [31:0] t_resp_res, t_ux, t_uy;
  logic t_iv, t_ir, t_ov = 0, t_busy = 0, t_dead = 0, t_hs = 0;
  logic [31:0] t_res = 0, t_r = 0;
  int t_cnt = 0;
  int n_cmp = 0, n_bad = 0, cyc = 0, hs_cyc = 0, mg;
  logic [63:0] mu;
  logic [34:0] mr;
  int gq[$];
  logic [63:0] uq[$];
  logic [34:0] rq[$];

  gcd_unit_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_res(resp_res), .resp_err(resp_err),
    .unit_input_ready(u_ir), .unit_input_valid(u_iv), .unit_x(unit_x), .unit_y(unit_y),
    .unit_output_valid(u_ov), .unit_res(u_res)
  );

  gcd_unit_arbiter #(.TIMEOUT(16)) dut_t (
    .clk(clk), .reset_n(reset_n), .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_x(t_req_x), .req_y(t_req_y), .resp_valid(t_resp_valid), .resp_ready(t_resp_ready),
    .resp_id(t_resp_id), .resp_res(t_resp_res), .resp_err(t_resp_err),
    .unit_input_ready(t_ir), .unit_input_valid(t_iv), .unit_x(t_ux), .unit_y(t_uy),
    .unit_output_valid(t_ov), .unit_res(t_res)
  );

  function automatic logic [31:0] gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // unit model, latency 20, drops output_valid on accept
  assign u_ir = ir_en && !busy;
  always @(posedge clk)
    if (busy) begin
      if (cnt == 1) begin
        busy <= 0;
        u_ov <= 1;
        u_res <= m_r;
      end
      cnt <= cnt - 1;
    end else if (u_iv && u_ir) begin
      busy <= 1;
      cnt <= 20;
      u_ov <= 0;
      m_r <= gcd(unit_x, unit_y);
    end

  // second unit model, latency 3, silent while t_dead
  assign t_ir = !t_busy;
  always @(posedge clk)
    if (t_busy) begin
      if (t_cnt == 1) begin
        t_busy <= 0;
        t_ov <= !t_dead;
        t_res <= t_r;
      end
      t_cnt <= t_cnt - 1;
    end else if (t_iv && t_ir) begin
      t_busy <= 1;
      t_cnt <= 3;
      t_ov <= 0;
      t_r <= gcd(t_ux, t_uy);
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (req_ready != 0) begin
      if (gq.size() == 0) chk("grant_unexpected", 64'(req_ready), 64'd0);
      else begin
        mg = gq.pop_front();
        chk("grant", 64'(req_ready), 64'd1 << mg);
      end
    end
    if (u_iv && u_ir) begin
      if (uq.size() == 0) chk("unit_accept_unexpected", {unit_x, unit_y}, 64'd0);
      else begin
        mu = uq.pop_front();
        chk("unit_operands", {unit_x, unit_y}, mu);
      end
    end
    if (resp_valid && resp_ready) begin
      if (rq.size() == 0) chk("resp_unexpected", 64'({resp_id, resp_res, resp_err}), 64'd0);
      else begin
        mr = rq.pop_front();
        chk("resp", 64'({resp_id, resp_res, resp_err}), 64'(mr));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    pend = req_ready;
    t_pend = t_req_ready;
    t_hs = t_iv && t_ir;
    @(posedge clk);
    #2;
    cyc++;
    if (t_hs) hs_cyc = cyc;
    req_valid = req_valid & ~pend;
    t_req_valid = t_req_valid & ~t_pend;
  endtask

  task automatic push_op(input int id, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input bit full);
    gq.push_back(id);
    uq.push_back({x, y});
    if (full) rq.push_back({2'(id), r, 1'b0});
  endtask

  task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y);
    req_x[i*32 +: 32] = x;
    req_y[i*32 +: 32] = y;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int k = 0;
    while ((gq.size() != 0 || uq.size() != 0 || rq.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    chk({nm, "_drain_timeout"}, 64'(k < budget), 64'd1);
  endtask

  task automatic wait_t_resp(input int budget, input string nm);
    int k = 0;
    while (!t_resp_valid && k < budget) begin
      tick();
      k++;
    end
    chk({nm, "_resp_timeout"}, 64'(k < budget), 64'd1);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_ctl"}, 64'({req_ready, resp_valid, resp_id, resp_err, u_iv}), 64'd0);
    chk({nm, "_res"}, 64'(resp_res), 64'd0);
    chk({nm, "_ops"}, {unit_x, unit_y}, 64'd0);
  endtask

  initial begin
    int k;
    #1 reset_n = 0;
    #2 check_reset("reset");
    tick();
    tick();
    reset_n = 1;
    tick();
    // all four requesting from reset
    push_op(0, 48, 36, 12, 1);
    push_op(1, 7, 5, 1, 1);
    push_op(2, 100, 75, 25, 1);
    push_op(3, 21, 14, 7, 1);
    for (int i = 0; i < 4; i++) set_req(i, uq[i][63:32], uq[i][31:0]);
    wait_drain(400, "rr4");
    // pointer back at 0 with 0 and 3 requesting
    push_op(0, 81, 27, 27, 1);
    push_op(3, 17, 34, 17, 1);
    set_req(0, 81, 27);
    set_req(3, 17, 34);
    wait_drain(200, "rr03");
    push_op(2, 32'd3322124436, 32'd2637132290, 2, 1);
    set_req(2, 32'd3322124436, 32'd2637132290);
    wait_drain(100, "big");
    push_op(0, 12, 18, 6, 1);
    set_req(0, 12, 18);
    wait_drain(100, "small");
    // response backpressure with requests pending
    resp_ready = 0;
    push_op(2, 1071, 462, 21, 1);
    push_op(0, 270, 192, 6, 1);
    push_op(1, 64, 48, 16, 1);
    set_req(2, 1071, 462);
    tick();
    set_req(0, 270, 192);
    set_req(1, 64, 48);
    k = 0;
    while (!resp_valid && k < 100) begin
      tick();
      k++;
    end
    chk("stall_resp_timeout", 64'(k < 100), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_hold", 64'({resp_valid, resp_id, resp_res, resp_err, req_ready, u_iv}),
          64'({1'b1, 2'd2, 32'd21, 1'b0, 4'b0000, 1'b0}));
    end
    resp_ready = 1;
    tick();
    chk("grant_after_resp", 64'(req_ready), 64'b0001);
    wait_drain(200, "stall");
    // unit not ready in IDLE, then in ISSUE
    ir_en = 0;
    push_op(0, 35, 49, 7, 1);
    set_req(0, 35, 49);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_hold", 64'({req_ready, u_iv}), 64'd0);
    end
    ir_en = 1;
    tick();
    ir_en = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("issue_hold", 64'({u_iv, unit_x, unit_y}), 64'({1'b1, 32'd35, 32'd49}));
    end
    ir_en = 1;
    wait_drain(100, "ready_hold");
    // reset in the middle of BUSY
    push_op(2, 9, 6, 3, 1);
    set_req(2, 9, 6);
    wait_drain(100, "pre_reset");
    push_op(1, 99, 121, 0, 0);
    set_req(1, 99, 121);
    wait_drain(100, "abort");
    repeat (3) tick();
    reset_n = 0;
    #1 check_reset("mid_busy_reset");
    push_op(1, 99, 121, 11, 1);
    push_op(3, 1, 1, 1, 1);
    set_req(1, 99, 121);
    set_req(3, 1, 1);
    tick();
    tick();
    reset_n = 1;
    wait_drain(400, "after_reset");
    // watchdog on the TIMEOUT=16 instance
    t_dead = 1;
    t_req_x[31:0] = 12;
    t_req_y[31:0] = 18;
    t_req_valid[0] = 1;
    wait_t_resp(100, "tmo");
    chk("tmo_latency", 64'(cyc - hs_cyc), 64'd16);
    chk("tmo_resp", 64'({t_resp_id, t_resp_res, t_resp_err}), 64'({2'd0, 32'd0, 1'b1}));
    tick();
    t_dead = 0;
    t_req_x[63:32] = 48;
    t_req_y[63:32] = 36;
    t_req_valid[1] = 1;
    wait_t_resp(100, "t_ok");
    chk("t_ok_resp", 64'({t_resp_id, t_resp_res, t_resp_err}), 64'({2'd1, 32'd12, 1'b0}));
    tick();
    chk("queues_empty", 64'(gq.size() + uq.size() + rq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/gcd_unit_arbiter.md
Name: gcd_unit_arbiter

Overview:
Round-robin controller that shares one multi-cycle 32-bit two-operand compute unit (ready/valid start, level output_valid/res, e.g. the GCD core) between NREQ requesters. It accepts one request at a time, issues the operands to the unit and waits for the result with a watchdog. It then returns the result to the granted requester with backpressure. It sits between client blocks and the single shared datapath instance.

Parameters:
NREQ, 4, number of requesters (2..16)
W, 32, operand/result width
IDW, clog2(NREQ), requester id width
TIMEOUT, 1024, max cycles waiting for unit result; 0 disables watchdog

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester request pending
req_ready  out  NREQ  one-hot accept pulse
req_x  in  NREQ*W  operand x, requester i at bits [i*W +: W]
req_y  in  NREQ*W  operand y, same packing
resp_valid  out  1  result available
resp_ready  in  1  consumer takes result
resp_id  out  IDW  requester the result belongs to
resp_res  out  W  result
resp_err  out  1  1 = watchdog timeout, resp_res = 0
unit_input_ready  in  1  unit can accept operands
unit_input_valid  out  1  operands valid to unit
unit_x  out  W  operand x to unit
unit_y  out  W  operand y to unit
unit_output_valid  in  1  unit result valid (level)
unit_res  in  W  unit result

Behaviour:
- Reset (async assert, sync release): state IDLE, rr pointer 0, all outputs 0, ov_q 0, timeout counter 0. Reset mid-operation abandons it. The in-flight request is lost, and the requester must still hold req_valid to be re-served.
- Unit contract: accepts on an edge with unit_input_valid && unit_input_ready. It drops unit_output_valid within one cycle of accepting new operands. ov_q = registered unit_output_valid. A completion event is unit_output_valid && !ov_q.
- IDLE: if any req_valid and unit_input_ready, grant g = first set bit at or after pointer (wrapping, indices mod NREQ). req_ready[g]=1 for this cycle only (combinational from state/req_valid/pointer). Latch req_x[g], req_y[g], g on the edge. Go to ISSUE. Otherwise stay, req_ready=0.
- ISSUE: unit_input_valid=1, unit_x/unit_y = latched operands, held stable. On the handshake edge go to BUSY and clear the timeout counter.
- BUSY: unit_input_valid=0. The timeout counter increments each cycle.
  - On a completion event, latch resp_res=unit_res, resp_err=0, go RESP.
  - Else if TIMEOUT!=0 and counter reaches TIMEOUT-1, latch resp_res=0, resp_err=1, go RESP.
  - Completion and timeout in the same cycle: completion wins.
- RESP: resp_valid=1. resp_id, resp_res and resp_err stay stable until the handshake resp_valid && resp_ready. On the handshake edge, pointer = (g+1) mod NREQ and go IDLE. No grant occurs in RESP, so req_ready stays 0.
- Minimum latency: accept at cycle T, unit handshake at T+1 if unit_input_ready, resp_valid at the cycle after the completion edge. Back-to-back throughput is one op per (unit latency + 3) cycles.
- Requester changing req_x/req_y after its req_ready pulse has no effect. Deasserting req_valid before grant withdraws the request.

Test Plan:
- Bench GCD model (latency 20). Requester 2 sends x=3322124436, y=2637132290. Expect a single req_ready[2] pulse, unit_x=3322124436, unit_y=2637132290, then resp_valid with resp_id=2, resp_res=2, resp_err=0. Model result 6 for x=12, y=18.
- All 4 req_valid held from reset: grants in order 0,1,2,3. Then with only 3 and 0 requesting, pointer=0 gives grant 0 then 3. Each resp_id matches its grant.
- Hold resp_ready=0 for 10 cycles with requests pending: resp_valid, resp_id and resp_res stay stable, req_ready=0, unit_input_valid=0. After the handshake, the next grant occurs in IDLE one cycle later.
- TIMEOUT=16, model never asserts output_valid: resp_err=1, resp_res=0, 16 cycles after the unit handshake. The following request (model fixed) completes normally.
- Hold unit_input_ready=0 for 5 cycles in IDLE and in ISSUE: no grant in IDLE; in ISSUE, unit_input_valid and operands are held stable until ready, with exactly one unit accept.
- Assert reset_n=0 mid-BUSY: all outputs go 0 immediately (before the next clk edge) and pointer is 0. After release with req_valid[1] held, requester 1 is re-granted and gets the correct result.
